// File: rtl/alarm_minigame.sv
// Purpose : pattern-copy mini-game used by the alarm check to silence the alarm.
// Latency : all outputs registered, reflecting the state entered on each clk edge.
// Backpr. : none; inputs are sampled levels and presses are rising edges of i_push_m.
//
// Ports:
//   i_clk        system clock
//   i_resetn     synchronous reset, active HIGH despite the name
//   i_start      game request, honoured only while idle
//   i_abort      cancels a running game (alarm switched off externally)
//   i_spdt_game  10 mini-game switch levels
//   i_push_m     debounced middle push button (level)
//   o_led        LED drive: target pattern, all-on on failure, else off
//   o_busy       high whenever a game is in progress
//   o_done       one-cycle pulse after the final correct round
//   o_round      consecutive correct rounds so far
module alarm_minigame #(
    parameter int         ROUNDS      = 3,
    parameter int         FAIL_CYCLES = 4,
    parameter logic [9:0] LFSR_SEED   = 10'h2A5
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [9:0] i_spdt_game,
    input  logic       i_push_m,
    output logic [9:0] o_led,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_round
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHOW  = 3'd2,
        S_FAIL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_lfsr;
    logic [9:0]  w_lfsr_nxt;
    logic [9:0]  r_target;
    logic [9:0]  w_target_nxt;
    logic [3:0]  r_round;
    logic [3:0]  w_round_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_push_prev;
    logic        w_press;
    logic [9:0]  r_led;
    logic [9:0]  w_led_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic        r_done;
    logic        w_done_nxt;

    // Fibonacci taps 10/7 give a maximal-length sequence, so a nonzero
    // seed never reaches the all-zero lock-up state.
    assign w_lfsr_nxt = {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
    // Only a fresh press counts; a button already held entering SHOW is ignored.
    assign w_press    = i_push_m & ~r_push_prev;

    // State register (plus registered outputs)
    always_ff @(posedge i_clk) begin
        if (i_resetn) begin
            r_state     <= S_IDLE;
            r_lfsr      <= LFSR_SEED;
            r_target    <= 10'd0;
            r_round     <= 4'd0;
            r_cnt       <= 16'd0;
            r_push_prev <= 1'b0;
            r_led       <= 10'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_target    <= w_target_nxt;
            r_round     <= w_round_nxt;
            r_cnt       <= w_cnt_nxt;
            r_push_prev <= i_push_m;
            r_led       <= w_led_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_round_nxt  = r_round;
        w_cnt_nxt    = r_cnt;
        if (i_abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
            w_round_nxt = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_round_nxt = 4'd0;
                    // abort together with start keeps the game idle
                    if (i_start && !i_abort) w_state_nxt = S_CLEAR;
                end
                S_CLEAR: begin
                    // Wait for all switches down so the previous answer
                    // cannot be reused against the next pattern.
                    if (i_spdt_game == 10'd0) begin
                        w_target_nxt = r_lfsr;
                        w_state_nxt  = S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (w_press) begin
                        if (i_spdt_game == r_target) begin
                            w_round_nxt = r_round + 4'd1;
                            if (r_round + 4'd1 == ROUNDS[3:0]) w_state_nxt = S_DONE;
                            else                                w_state_nxt = S_CLEAR;
                        end else begin
                            w_round_nxt = 4'd0;
                            w_cnt_nxt   = FAIL_CYCLES[15:0];
                            w_state_nxt = S_FAIL;
                        end
                    end
                end
                S_FAIL: begin
                    if (r_cnt == 16'd1) w_state_nxt = S_CLEAR;
                    else                w_cnt_nxt   = r_cnt - 16'd1;
                end
                S_DONE: begin
                    w_round_nxt = 4'd0;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_round_nxt = 4'd0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Output logic: decoded from the state being entered so the registered
    // outputs line up with that state.
    always_comb begin
        w_led_nxt  = 10'd0;
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
        case (w_state_nxt)
            S_SHOW:  w_led_nxt = w_target_nxt;
            S_FAIL:  w_led_nxt = 10'h3FF;
            default: w_led_nxt = 10'd0;
        endcase
    end

    assign o_led   = r_led;
    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_round = r_round;

endmodule

// File: doc/alarm_minigame.md
# alarm_minigame

Mini-game responder that the alarm-check service drives when the alarm is in its mini-game state. On a `start` pulse it repeatedly shows a pseudo-random 10-bit pattern on the LEDs. The user must copy the pattern onto the 10 mini-game SPDT switches and confirm with the middle push button. After `ROUNDS` consecutive correct submissions it returns a one-cycle `done` pulse, which the alarm check uses to turn the alarm off. It sits between the alarm-check service, the `spdt[9:0]` switches, `push_m` and `led[9:0]` in `Main`.

## Interface
- `ROUNDS`, 3: consecutive correct rounds required; legal range 1..15.
- `FAIL_CYCLES`, 4: cycles the failure indication is held; legal range 1..65535.
- `LFSR_SEED`, 10'h2A5: LFSR reset value; must be nonzero.

- `clk`  in  1  system clock; single clock domain.
- `resetn`  in  1  reset, synchronous and active-high (1 = reset) despite the name.
- `start`  in  1  game request from the alarm check; sampled only in IDLE.
- `abort`  in  1  alarm switched off externally (SPDT4 low); cancels the game.
- `spdt_game`  in  10  mini-game switch levels.
- `push_m`  in  1  middle push button, already debounced, level.
- `led`  out  10  registered LED drive.
- `busy`  out  1  registered; high in every state except IDLE.
- `done`  out  1  registered; one-cycle pulse on successful completion.
- `round`  out  4  registered count of correct rounds so far.

## Operation
- LFSR: 10-bit Fibonacci, feedback `q[9]^q[6]` shifted into `q[0]`. Advances every cycle from reset and never reaches zero.
- Push edge: `push_prev <= push_m` every cycle. `press = push_m & ~push_prev`.
- States and transitions:
  - IDLE: led=0, round=0. `start` → CLEAR.
  - CLEAR: led=0. Waits for `spdt_game==0`. On that cycle, target <= LFSR value, → SHOW.
  - SHOW: led=target. On `press`:
    - `spdt_game==target` and round+1==ROUNDS → round<=round+1, → DONE.
    - `spdt_game==target` otherwise → round<=round+1, → CLEAR.
    - mismatch → round<=0, counter<=FAIL_CYCLES, → FAIL.
  - FAIL: led=10'h3FF. Counter decrements each cycle; on reaching 1 → CLEAR.
  - DONE: done=1 for exactly this cycle, led=0, → IDLE.
- Priority: `resetn` > `abort` > state logic. `abort` in any non-IDLE state → IDLE next cycle, round=0, no `done`.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: stays IDLE.
- `press` outside SHOW is ignored. A button held down when SHOW is entered is not counted; the button must be released and pressed again.
- Switch compare is exact over all 10 bits. Extra raised switches count as a mismatch.

## Timing
- Reset values: led=0, busy=0, done=0, round=0, state=IDLE, push_prev=0, LFSR=LFSR_SEED, target=0.
- All outputs are registered and reflect the state entered on that edge.
- `start` high at edge t → busy=1 after edge t.
- If switches are already zero, SHOW is entered after edge t+1 and led=target from then on.
- `press` sampled at edge e, match on the final round → done=1 after edge e. done=0 and busy=0 after edge e+1.
- Mismatch at edge e → led=3FF after edges e..e+FAIL_CYCLES-1, CLEAR after edge e+FAIL_CYCLES.
- `push_m` rising across edges e-1/e, combined with the spdt value at edge e, forms one submission.
- Synchronous reset mid-game returns everything to the reset values on the next edge.

## Test plan
- Reset, then hold resetn=1 for 2 cycles → led=0, busy=0, done=0, round=0. After release, the LFSR sequence matches the model from seed 2A5.
- start pulse with switches 0; each round copy `led` onto `spdt_game` and pulse push_m (ROUNDS=3) → round goes 1,2,3. Exactly one done pulse, then busy=0.
- In round 2, set the switches to led^10'h001 and press → led=3FF for 4 cycles, round=0. The game restarts in CLEAR and a full 3-round success is still reachable.
- After round 1, leave the switches at the old pattern → state stays CLEAR with led=0 until switches=0, then a new target is shown.
- Assert abort in SHOW with round=2 → next cycle busy=0, round=0, no done. A start with abort held in IDLE is ignored.
- Hold push_m high through entry to SHOW with the correct pattern → no round increment until push_m falls and rises again. A start pulse while busy leaves state unchanged.
